csa_multibyte_sequencer: RTL and testbench

Byte-serial multi-precision add/subtract controller. It time-shares one 8-bit conditional_sum_adder instance across the NBYTES bytes of two wide operands, least-significant byte first. The carry is chained between bytes through a register. It sits between a requesting datapath and the adder, using a start/busy/done handshake.

---
 rtl/csa_multibyte_sequencer_if.sv | 28 ++
 rtl/csa_multibyte_sequencer.sv | 123 ++++++++++++
 tb/tb_csa_multibyte_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/csa_multibyte_sequencer_if.sv
// rtl/csa_multibyte_sequencer_if.sv - request/result bundle between the datapath and the byte-serial add/sub sequencer.
// The master is the requesting datapath. The slave is the sequencer.
interface csa_multibyte_sequencer_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, result, cout, overflow
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, result, cout, overflow
   );
endinterface

// File: rtl/csa_multibyte_sequencer.sv
// rtl/csa_multibyte_sequencer.sv - multi-precision add/sub that reuses one 8-bit conditional-sum adder, LS byte first.
// Subtraction is performed as a + ~b + 1; the carry between bytes is held in a register.
module conditional_sum_adder (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       cin,
   output logic       cout,
   output logic [7:0] correctSum
);
   logic [4:0] lo;
   logic [4:0] hi0;
   logic [4:0] hi1;

   // Both upper-nibble sums are precomputed; the low-nibble carry selects one of them.
   assign lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0000, cin};
   assign hi0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
   assign hi1 = hi0 + 5'd1;

   assign correctSum = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
   assign cout       = lo[4] ? hi1[4] : hi0[4];
endmodule

module csa_multibyte_sequencer #(
   parameter int NBYTES = 4
) (
   input logic                     clk,
   input logic                     rst,
   csa_multibyte_sequencer_if.slave bus
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [IDXW-1:0] idx;
   logic            carry;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    result_q;
   logic            cout_q;
   logic            overflow_q;
   logic            busy_q;
   logic            done_q;

   logic [IDXW+2:0] base;
   logic [7:0]      x_byte;
   logic [7:0]      y_byte;
   logic [7:0]      sum_byte;
   logic            byte_cout;

   assign base   = {idx, 3'b000};
   assign x_byte = a_reg[base +: 8];
   assign y_byte = b_reg[base +: 8];

   conditional_sum_adder u_adder (
      .x          (x_byte),
      .y          (y_byte),
      .cin        (carry),
      .cout       (byte_cout),
      .correctSum (sum_byte)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         carry      <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_reg      <= bus.a;
                  b_reg      <= bus.sub ? ~bus.b : bus.b;
                  carry      <= bus.sub ? 1'b1 : bus.cin;
                  idx        <= '0;
                  result_q   <= '0;
                  cout_q     <= 1'b0;
                  overflow_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               result_q[base +: 8] <= sum_byte;
               carry               <= byte_cout;
               if (idx == LAST) begin
                  // Signed overflow is judged on the top byte against the already-inverted b.
                  cout_q     <= byte_cout;
                  overflow_q <= (x_byte[7] == y_byte[7]) && (sum_byte[7] != x_byte[7]);
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_csa_multibyte_sequencer.sv
// tb/tb_csa_multibyte_sequencer.sv - self-checking bench for csa_multibyte_sequencer (NBYTES=4 and NBYTES=1).
module tb_csa_multibyte_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   csa_multibyte_sequencer_if #(.NBYTES(4)) if4 ();
   csa_multibyte_sequencer_if #(.NBYTES(1)) if1 ();

   csa_multibyte_sequencer #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   csa_multibyte_sequencer #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                        output logic [31:0] r, output logic co, output logic ov);
      longint u;
      longint s;
      if (sub) begin
         u  = longint'(a) - longint'(b);
         s  = longint'($signed(a)) - longint'($signed(b));
         co = (a >= b);
      end else begin
         u  = longint'(a) + longint'(b) + longint'(cin);
         s  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
         co = (u >= 64'sd4294967296);
      end
      r  = u[31:0];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endtask

   // Issues one request on if4 and observes it; lat is cycles after the accept edge minus one, or -1 on timeout.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                        input int junk_starts,
                        output logic [31:0] r, output logic co, output logic ov,
                        output int lat, output int busy_cnt, output int done_cnt);
      lat = -1; busy_cnt = 0; done_cnt = 0; r = '0; co = 1'b0; ov = 1'b0;
      if4.start = 1'b1; if4.a = a; if4.b = b; if4.sub = sub; if4.cin = cin;
      @(posedge clk); #1;
      if4.start = 1'b0;
      for (int j = 0; j < 12; j++) begin
         if (if4.busy) busy_cnt++;
         if (if4.done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = j; r = if4.result; co = if4.cout; ov = if4.overflow;
            end
         end
         if (j < junk_starts) begin
            if4.start = 1'b1; if4.a = $urandom; if4.b = $urandom; if4.sub = 1'($urandom); if4.cin = 1'($urandom);
         end else begin
            if4.start = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin, input int junk);
      logic [31:0] r, er;
      logic co, ov, eco, eov;
      int lat, bc, dc;
      model(a, b, sub, cin, er, eco, eov);
      do_op(a, b, sub, cin, junk, r, co, ov, lat, bc, dc);
      total_cnt++; if (r !== er) $display("FAIL %s result got %h exp %h", name, r, er); else pass_cnt++;
      total_cnt++; if (co !== eco) $display("FAIL %s cout got %b exp %b", name, co, eco); else pass_cnt++;
      total_cnt++; if (ov !== eov) $display("FAIL %s overflow got %b exp %b", name, ov, eov); else pass_cnt++;
      total_cnt++; if (lat !== 4) $display("FAIL %s latency got %0d exp 4", name, lat); else pass_cnt++;
      total_cnt++; if (bc !== 4) $display("FAIL %s busy_cycles got %0d exp 4", name, bc); else pass_cnt++;
      total_cnt++; if (dc !== 1) $display("FAIL %s done_pulses got %0d exp 1", name, dc); else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      total_cnt++;
      if ({if4.busy, if4.done, if4.cout, if4.overflow} !== 4'b0 || if4.result !== 32'h0)
         $display("FAIL reset_state got busy=%b done=%b res=%h", if4.busy, if4.done, if4.result);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      check_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
      check_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
      check_op("add_cin",    32'h12345678, 32'h11111111, 1'b0, 1'b1, 0);
      check_op("sub_neg",    32'h00000005, 32'h00000007, 1'b1, 1'b1, 0);
      check_op("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 0);
   endtask

   task automatic test_ignore_start();
      check_op("ignore_start", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 3);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 16; i++) begin
         a = $urandom; b = $urandom;
         if (i % 4 == 0) b = a;
         check_op("random", a, b, 1'($urandom), 1'($urandom), 0);
      end
   endtask

   task automatic test_abort();
      int dc = 0;
      if4.start = 1'b1; if4.a = 32'h01020304; if4.b = 32'h10203040; if4.sub = 1'b0; if4.cin = 1'b0;
      @(posedge clk); #1;
      if4.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total_cnt++;
      if ({if4.busy, if4.done, if4.cout, if4.overflow} !== 4'b0 || if4.result !== 32'h0)
         $display("FAIL abort_state got busy=%b done=%b res=%h", if4.busy, if4.done, if4.result);
      else pass_cnt++;
      for (int j = 0; j < 8; j++) begin
         if (if4.done || if4.busy) dc++;
         @(posedge clk); #1;
      end
      total_cnt++; if (dc !== 0) $display("FAIL abort_no_done got %0d active cycles exp 0", dc); else pass_cnt++;
      check_op("after_abort", 32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      int t1 = -1, t2 = -1;
      logic [31:0] r1 = '0, r2 = '0;
      if4.start = 1'b1; if4.a = 32'h00000001; if4.b = 32'h00000001; if4.sub = 1'b0; if4.cin = 1'b0;
      @(posedge clk); #1;
      if4.a = 32'hFFFFFFFF; if4.b = 32'h00000000;
      for (int j = 0; j < 14; j++) begin
         if (if4.done) begin
            if (t1 < 0) begin t1 = j; r1 = if4.result; end
            else if (t2 < 0) begin t2 = j; r2 = if4.result; end
         end
         if (t1 >= 0 && j > t1) if4.start = 1'b0;
         @(posedge clk); #1;
      end
      if4.start = 1'b0;
      total_cnt++; if (t1 !== 4) $display("FAIL b2b_first_done got %0d exp 4", t1); else pass_cnt++;
      total_cnt++; if (t2 - t1 !== 5) $display("FAIL b2b_spacing got %0d exp 5", t2 - t1); else pass_cnt++;
      total_cnt++; if (r1 !== 32'h2) $display("FAIL b2b_result1 got %h exp 00000002", r1); else pass_cnt++;
      total_cnt++; if (r2 !== 32'hFFFFFFFF) $display("FAIL b2b_result2 got %h exp ffffffff", r2); else pass_cnt++;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_nbytes1();
      logic [7:0] av [2] = '{8'h80, 8'h05};
      logic [7:0] bv [2] = '{8'h80, 8'h07};
      logic       sv [2] = '{1'b0, 1'b1};
      logic [9:0] ev [2] = '{{1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 8'hFE}};
      for (int k = 0; k < 2; k++) begin
         int lat = -1;
         logic [9:0] got = '0;
         if1.start = 1'b1; if1.a = av[k]; if1.b = bv[k]; if1.sub = sv[k]; if1.cin = 1'b0;
         @(posedge clk); #1;
         if1.start = 1'b0;
         for (int j = 0; j < 5; j++) begin
            if (if1.done && lat < 0) begin lat = j; got = {if1.cout, if1.overflow, if1.result}; end
            @(posedge clk); #1;
         end
         total_cnt++; if (got !== ev[k]) $display("FAIL nbytes1_%0d got %h exp %h", k, got, ev[k]); else pass_cnt++;
         total_cnt++; if (lat !== 1) $display("FAIL nbytes1_latency_%0d got %0d exp 1", k, lat); else pass_cnt++;
      end
   endtask

   initial begin
      if4.start = 1'b0; if4.sub = 1'b0; if4.cin = 1'b0; if4.a = '0; if4.b = '0;
      if1.start = 1'b0; if1.sub = 1'b0; if1.cin = 1'b0; if1.a = '0; if1.b = '0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_random();
      test_abort();
      test_back_to_back();
      test_nbytes1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
